riscv_ex_tag_unit: RTL



---
 rtl/riscv_ex_tag_unit.sv | 94 +++++++++
 1 files changed

// File: rtl/riscv_ex_tag_unit.sv
// riscv_ex_tag_unit: multi-bit DIFT tag path for EX with a programmable propagation policy,
// PC/WB tag registers and a control-flow tag-check trap FSM with saturating violation count.
module riscv_ex_tag_unit #(
    parameter int TAG_WIDTH = 4,
    parameter int NUM_MODES = 8,
    parameter int CNT_WIDTH = 16,
    localparam int MODE_WIDTH = $clog2(NUM_MODES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [MODE_WIDTH-1:0] mode_i,
    input  logic [TAG_WIDTH-1:0]  op_a_tag_i,
    input  logic [TAG_WIDTH-1:0]  op_b_tag_i,
    input  logic [TAG_WIDTH-1:0]  op_c_tag_i,
    input  logic                  valid_i,
    input  logic                  branch_in_ex_i,
    input  logic                  branch_taken_i,
    input  logic                  regfile_we_i,
    input  logic                  data_we_i,
    input  logic                  wb_ready_i,
    input  logic                  cfg_we_i,
    input  logic [MODE_WIDTH-1:0] cfg_idx_i,
    input  logic [3:0]            cfg_policy_i,
    input  logic [TAG_WIDTH-1:0]  trap_mask_i,
    input  logic                  trap_ack_i,
    output logic [TAG_WIDTH-1:0]  result_tag_o,
    output logic [TAG_WIDTH-1:0]  data_tag_o,
    output logic                  data_tag_we_o,
    output logic [TAG_WIDTH-1:0]  pc_tag_o,
    output logic [TAG_WIDTH-1:0]  wb_tag_o,
    output logic                  wb_tag_we_o,
    output logic                  trap_o,
    output logic [TAG_WIDTH-1:0]  trap_tag_o,
    output logic [CNT_WIDTH-1:0]  viol_cnt_o
);
    typedef enum logic {IDLE, TRAP} state_t;
    state_t state_q, state_d;
    logic [3:0] policy_q [NUM_MODES];
    logic [3:0] pol;
    logic prop_en, check_en, taken, violation, load_trap_tag;
    logic [TAG_WIDTH-1:0] next_pc_tag;
    assign pol = policy_q[mode_i];
    assign prop_en = pol[2];
    assign check_en = pol[3];
    assign result_tag_o = (pol[1:0] == 2'b00) ? '0 :
                          (pol[1:0] == 2'b01) ? (op_a_tag_i | op_b_tag_i) :
                          (pol[1:0] == 2'b10) ? (op_a_tag_i & op_b_tag_i) : op_a_tag_i;
    assign data_tag_o = result_tag_o;
    assign data_tag_we_o = valid_i & data_we_i & prop_en;
    assign taken = valid_i & branch_in_ex_i & branch_taken_i;
    // A non-zero jump-target tag always wins; otherwise fall back to the combined tag or hold.
    assign next_pc_tag = (op_c_tag_i != '0) ? op_c_tag_i : (prop_en ? result_tag_o : pc_tag_o);
    assign violation = taken & check_en & (|(next_pc_tag & trap_mask_i));
    assign trap_o = (state_q == TRAP);
    always_comb begin
        state_d = state_q;
        load_trap_tag = 1'b0;
        if (state_q == IDLE) begin
            state_d = violation ? TRAP : IDLE;
            load_trap_tag = violation;
        end else begin
            state_d = (trap_ack_i && !violation) ? IDLE : TRAP;
            load_trap_tag = trap_ack_i & violation;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_MODES; i++) policy_q[i] <= 4'b0101;
        end else if (cfg_we_i) begin
            policy_q[cfg_idx_i] <= cfg_policy_i;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_tag_o    <= '0;
            wb_tag_o    <= '0;
            wb_tag_we_o <= 1'b0;
            trap_tag_o  <= '0;
            viol_cnt_o  <= '0;
        end else begin
            state_q <= state_d;
            if (taken) pc_tag_o <= next_pc_tag;
            if (valid_i) begin
                wb_tag_we_o <= regfile_we_i & prop_en;
                if (regfile_we_i) wb_tag_o <= result_tag_o;
            end else if (wb_ready_i) begin
                wb_tag_we_o <= 1'b0;
            end
            if (load_trap_tag) trap_tag_o <= next_pc_tag;
            if (violation && viol_cnt_o != '1) viol_cnt_o <= viol_cnt_o + 1'b1;
        end
    end
endmodule
